bit_8_alu: RTL and testbench
============================

BIT_8_ALU -- requirements
Module: bit_8_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; only 8 is required to be supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: A  input  8  operand A, unsigned/two's-complement bit vector.
REQ-005 Port: B  input  8  operand B.
REQ-006 Port: ALU_Sel  input  3  operation select.
REQ-007 Port: Cin  input  1  carry-in for ADD; borrow-in for SUB.
REQ-008 Port: ALU_Out  output  8  registered result.
REQ-009 Port: Cout  output  1  registered carry-out (ADD) or borrow-out (SUB).
REQ-010 Ports Zero (output, 1, result==0) and Ovf (output, 1, signed overflow) SHALL exist only when BIT_8_ALU_STATUS_EN is defined.

Function
REQ-011 ALU_Sel 000 SHALL select AND: A & B.
REQ-012 ALU_Sel 001 SHALL select OR: A | B.
REQ-013 ALU_Sel 010 SHALL select XOR: A ^ B.
REQ-014 ALU_Sel 011 SHALL select ADD: {Cout,ALU_Out} = A + B + Cin, 9-bit sum, carry is bit 8.
REQ-015 ALU_Sel 100 SHALL select SUB: {Cout,ALU_Out} = A - B - Cin, mod 256; Cout=1 iff A < B + Cin (borrow).
REQ-016 ALU_Sel 101 SHALL pass A; 110 SHALL pass B; 111 SHALL output ~A.
REQ-017 For all non-arithmetic ops (000,001,010,101,110,111), Cout SHALL be 0 and Cin SHALL be ignored.
REQ-018 Result, Cout (and flags) SHALL be computed combinationally and captured into output registers on each rising clk edge; latency exactly 1 cycle, new operation accepted every cycle, no handshake.
REQ-019 Outputs SHALL hold their value between edges regardless of input changes.
REQ-020 Boundary: ADD 0xFF+0x00+1 SHALL yield 0x00, Cout=1; SUB 0x00-0x00-1 SHALL yield 0xFF, Cout=1.
REQ-021 Any X-free ALU_Sel value SHALL produce a defined result; no latches, no illegal encodings.

Reset
REQ-022 While rst=1, ALU_Out SHALL be 0x00 and Cout 0 (Zero 1, Ovf 0 when status enabled), immediately without waiting for clk.
REQ-023 Reset asserted mid-operation SHALL discard the pending capture; first valid result appears at the first rising edge after rst deasserts.

Configuration
REQ-024 Macro BIT_8_ALU_STATUS_EN: when defined, Zero and Ovf ports and registers SHALL be compiled in; when undefined, they SHALL be absent and core behaviour SHALL be unchanged.
REQ-025 Zero SHALL be 1 iff the registered ALU_Out is 0x00, for every op.
REQ-026 Ovf SHALL be 1 for ADD when A[7]==B[7] and result[7]!=A[7]; for SUB when A[7]!=B[7] and result[7]!=A[7]; 0 for all other ops.

Verification
REQ-027 A=0x4D, B=0x43, Cin=0, ALU_Sel 000..111 one per cycle -> after 1 cycle each: 0x41, 0x4F, 0x0E, 0x90, 0x0A, 0x4D, 0x43, 0xB2; Cout 0 throughout (Ovf=1 on ADD when enabled).
REQ-028 ADD A=0xFF, B=0x01, Cin=1 -> ALU_Out 0x01, Cout 1; SUB A=0x00, B=0x01, Cin=0 -> ALU_Out 0xFF, Cout 1.
REQ-029 AND with Cin=1, A=0xF0, B=0x0F -> ALU_Out 0x00, Cout 0, Zero 1 (when enabled).
REQ-030 Assert rst between clock edges with ALU_Out nonzero -> ALU_Out 0x00, Cout 0 immediately; release rst, apply ADD 0x01+0x01 -> 0x02 one edge later.
REQ-031 Change A/B between edges -> outputs stable until next rising edge; build with and without BIT_8_ALU_STATUS_EN both pass REQ-027.

Source files
------------

// File: rtl/bit_8_alu.sv
// bit_8_alu: registered 8-bit ALU (AND/OR/XOR/ADD/SUB/pass A/pass B/NOT A).
// The result and carry/borrow are computed combinationally and captured on
// every rising clk edge; one-cycle latency, a new operation every cycle.
// Optional build macro BIT_8_ALU_STATUS_EN adds registered Zero and Ovf
// status outputs; without it the core behaviour is identical.
module bit_8_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALU_Sel,
   input  logic             Cin,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             Cout
`ifdef BIT_8_ALU_STATUS_EN
   ,
   output logic             Zero,
   output logic             Ovf
`endif
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_ADD  = 3'b011,
      OP_SUB  = 3'b100,
      OP_PASA = 3'b101,
      OP_PASB = 3'b110,
      OP_NOTA = 3'b111
   } alu_op_t;

   alu_op_t          op;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] res_next;
   logic             cout_next;

   assign op = alu_op_t'(ALU_Sel);

   // Bit WIDTH of the widened sum is the carry; of the widened difference it
   // is the borrow, since A - B - Cin < 0 wraps to a value with that bit set.
   assign sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
   assign diff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};

   // Operation decode; every encoding is defined and Cin only feeds ADD/SUB.
   always_comb begin
      res_next  = '0;
      cout_next = 1'b0;
      case (op)
         OP_AND:  res_next = A & B;
         OP_OR:   res_next = A | B;
         OP_XOR:  res_next = A ^ B;
         OP_ADD: begin
            res_next  = sum[WIDTH-1:0];
            cout_next = sum[WIDTH];
         end
         OP_SUB: begin
            res_next  = diff[WIDTH-1:0];
            cout_next = diff[WIDTH];
         end
         OP_PASA: res_next = A;
         OP_PASB: res_next = B;
         OP_NOTA: res_next = ~A;
         default: res_next = '0;
      endcase
   end

   // Output registers; reset clears them immediately without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ALU_Out <= '0;
         Cout    <= 1'b0;
      end else begin
         ALU_Out <= res_next;
         Cout    <= cout_next;
      end
   end

`ifdef BIT_8_ALU_STATUS_EN
   logic ovf_next;

   // Signed overflow: ADD of like-signed operands, or SUB of unlike-signed
   // operands, whose result sign differs from A.
   always_comb begin
      ovf_next = 1'b0;
      case (op)
         OP_ADD:  ovf_next = (A[WIDTH-1] == B[WIDTH-1]) &&
                             (res_next[WIDTH-1] != A[WIDTH-1]);
         OP_SUB:  ovf_next = (A[WIDTH-1] != B[WIDTH-1]) &&
                             (res_next[WIDTH-1] != A[WIDTH-1]);
         default: ovf_next = 1'b0;
      endcase
   end

   // Status registers track the result register; a cleared result is zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Zero <= 1'b1;
         Ovf  <= 1'b0;
      end else begin
         Zero <= (res_next == '0);
         Ovf  <= ovf_next;
      end
   end
`endif

endmodule

// File: tb/tb_bit_8_alu.sv
// Directed self-checking bench for bit_8_alu. Status outputs are connected
// and checked only when BIT_8_ALU_STATUS_EN is defined.
module tb_bit_8_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] A;
   logic [7:0] B;
   logic [2:0] ALU_Sel;
   logic       Cin;
   logic [7:0] ALU_Out;
   logic       Cout;
`ifdef BIT_8_ALU_STATUS_EN
   logic       Zero;
   logic       Ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   bit_8_alu #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .ALU_Sel (ALU_Sel),
      .Cin     (Cin),
      .ALU_Out (ALU_Out),
      .Cout    (Cout)
`ifdef BIT_8_ALU_STATUS_EN
      ,
      .Zero    (Zero),
      .Ovf     (Ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag, input logic exp_zero, input logic exp_ovf);
`ifdef BIT_8_ALU_STATUS_EN
      check({tag, ".zero"}, {7'd0, Zero}, {7'd0, exp_zero});
      check({tag, ".ovf"},  {7'd0, Ovf},  {7'd0, exp_ovf});
`endif
   endtask

   // Drive one operation at the falling edge, then sample just after the
   // capturing rising edge.
   task automatic run(input string tag, input logic [2:0] s, input logic [7:0] a,
                      input logic [7:0] b, input logic c, input logic [7:0] exp_out,
                      input logic exp_c, input logic exp_ovf);
      @(negedge clk);
      ALU_Sel = s; A = a; B = b; Cin = c;
      @(posedge clk);
      #1;
      check({tag, ".out"},  ALU_Out, exp_out);
      check({tag, ".cout"}, {7'd0, Cout}, {7'd0, exp_c});
      check_status(tag, exp_out == 8'h00, exp_ovf);
   endtask

   initial begin
      rst = 1'b1; A = 8'h00; B = 8'h00; ALU_Sel = 3'b000; Cin = 1'b0;
      #1;
      check("reset.out",  ALU_Out, 8'h00);
      check("reset.cout", {7'd0, Cout}, 8'h00);
      check_status("reset", 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reference vector set, A=0x4D B=0x43
      run("and",  3'b000, 8'h4D, 8'h43, 1'b0, 8'h41, 1'b0, 1'b0);
      run("or",   3'b001, 8'h4D, 8'h43, 1'b0, 8'h4F, 1'b0, 1'b0);
      run("xor",  3'b010, 8'h4D, 8'h43, 1'b0, 8'h0E, 1'b0, 1'b0);
      run("add",  3'b011, 8'h4D, 8'h43, 1'b0, 8'h90, 1'b0, 1'b1);
      run("sub",  3'b100, 8'h4D, 8'h43, 1'b0, 8'h0A, 1'b0, 1'b0);
      run("pasa", 3'b101, 8'h4D, 8'h43, 1'b0, 8'h4D, 1'b0, 1'b0);
      run("pasb", 3'b110, 8'h4D, 8'h43, 1'b0, 8'h43, 1'b0, 1'b0);
      run("nota", 3'b111, 8'h4D, 8'h43, 1'b0, 8'hB2, 1'b0, 1'b0);

      // Carry / borrow boundaries
      run("add_ff_00_c1", 3'b011, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      run("sub_00_00_b1", 3'b100, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      run("add_ff_01_c1", 3'b011, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
      run("sub_00_01",    3'b100, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run("add_7f_01",    3'b011, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run("sub_80_01",    3'b100, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run("add_c1",       3'b011, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
      run("sub_b1",       3'b100, 8'h10, 8'h05, 1'b1, 8'h0A, 1'b0, 1'b0);

      // Cin ignored by logic ops
      run("and_cin", 3'b000, 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
      run("or_cin",  3'b001, 8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b0, 1'b0);
      run("nota_cin",3'b111, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      run("pasb_cin",3'b110, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0);

      // Outputs hold between edges while inputs change
      run("hold_base", 3'b011, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
      A = 8'hFF; B = 8'hFF; ALU_Sel = 3'b100; Cin = 1'b1;
      #3;
      check("hold.out",  ALU_Out, 8'h46);
      check("hold.cout", {7'd0, Cout}, 8'h00);
      A = 8'h00; B = 8'h01; Cin = 1'b0;
      #3;
      check("hold2.out", ALU_Out, 8'h46);
      @(posedge clk);
      #1;
      check("hold_next.out",  ALU_Out, 8'hFF);
      check("hold_next.cout", {7'd0, Cout}, 8'h01);

      // Async reset mid-cycle with a nonzero result held
      #2;
      rst = 1'b1;
      #1;
      check("rst_async.out",  ALU_Out, 8'h00);
      check("rst_async.cout", {7'd0, Cout}, 8'h00);
      check_status("rst_async", 1'b1, 1'b0);
      ALU_Sel = 3'b011; A = 8'h01; B = 8'h01; Cin = 1'b0;
      @(posedge clk);
      #1;
      check("rst_held.out", ALU_Out, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_release.out",  ALU_Out, 8'h02);
      check("rst_release.cout", {7'd0, Cout}, 8'h00);
      check_status("rst_release", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
